// File: rtl/cond_unit_if.sv
// cond_unit bundle: decoder and ALU inputs, gated write enables,
// architectural flags and debug counters.
interface cond_unit_if #(parameter int CNT_W = 32);
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             Stall;
    logic             CntClr;
    logic             CondEx;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SkipCount;
    logic             UndefSeen;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        output NoWrite, Stall, CntClr,
        input  CondEx, PCSrc, RegWrite, MemWrite,
        input  Flags, ExecCount, SkipCount, UndefSeen
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        input  NoWrite, Stall, CntClr,
        output CondEx, PCSrc, RegWrite, MemWrite,
        output Flags, ExecCount, SkipCount, UndefSeen
    );
endinterface

// File: rtl/cond_unit.sv
// ARM conditional-execution stage: NZCV register, condition check,
// write-enable gating and saturating exec/skip debug counters.
module cond_unit #(
    parameter int CNT_W = 32
) (
    input logic        clk,
    input logic        reset,
    cond_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [3:0]       flags_q;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] skip_q;
    logic             undef_q;
    logic             condex;
    logic             n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        condex = 1'b0;
        unique case (bus.Cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            4'b1111: condex = 1'b0;
        endcase
    end

    assign bus.CondEx    = condex;
    assign bus.PCSrc     = bus.PCS & condex & ~bus.Stall;
    assign bus.RegWrite  = bus.RegW & condex & ~bus.NoWrite & ~bus.Stall;
    assign bus.MemWrite  = bus.MemW & condex & ~bus.Stall;
    assign bus.Flags     = flags_q;
    assign bus.ExecCount = exec_q;
    assign bus.SkipCount = skip_q;
    assign bus.UndefSeen = undef_q;

    // Flags see the old value this cycle; the update lands for the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (!bus.Stall && condex) begin
            if (bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end

    // Clear takes priority over a stall and over any increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_q  <= '0;
            skip_q  <= '0;
            undef_q <= 1'b0;
        end else if (bus.CntClr) begin
            exec_q  <= '0;
            skip_q  <= '0;
            undef_q <= 1'b0;
        end else if (!bus.Stall) begin
            if (condex && exec_q != CMAX)
                exec_q <= exec_q + CNT_W'(1);
            if (!condex && skip_q != CMAX)
                skip_q <= skip_q + CNT_W'(1);
            if (bus.Cond == 4'b1111)
                undef_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit with a narrow counter width so that
// saturation is reachable in a handful of cycles.
module tb_cond_unit;
    localparam int W = 4;

    typedef struct packed {
        logic [3:0] cond;
        logic [3:0] aluf;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowr;
        logic       stall;
        logic       clr;
    } instr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    cond_unit_if #(.CNT_W(W)) bus();
    cond_unit #(.CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [3:0]  cq[$];
    logic [12:0] sq[$];

    logic [3:0]   mflags = 4'b0000;
    logic [W-1:0] mexec = '0;
    logic [W-1:0] mskip = '0;
    logic         mundef = 1'b0;
    instr_t       cur;

    function automatic logic mcond(logic [3:0] c, logic [3:0] f);
        logic nf, zf, cf, vf, base;
        {nf, zf, cf, vf} = f;
        case (c[3:1])
            3'd0: base = zf;
            3'd1: base = cf;
            3'd2: base = nf;
            3'd3: base = vf;
            3'd4: base = cf & ~zf;
            3'd5: base = (nf == vf);
            3'd6: base = ~zf & (nf == vf);
            default: base = 1'b1;
        endcase
        if (c == 4'b1110) return 1'b1;
        if (c == 4'b1111) return 1'b0;
        return c[0] ? ~base : base;
    endfunction

    function automatic instr_t mk(logic [3:0] c, logic [3:0] a,
                                  logic [1:0] fw, logic p, logic r,
                                  logic m, logic nw, logic st,
                                  logic cl);
        instr_t i;
        i.cond = c; i.aluf = a; i.flagw = fw;
        i.pcs = p; i.regw = r; i.memw = m;
        i.nowr = nw; i.stall = st; i.clr = cl;
        return i;
    endfunction

    task automatic drive(instr_t i);
        logic ce;
        cur = i;
        bus.Cond = i.cond;
        bus.ALUFlags = i.aluf;
        bus.FlagW = i.flagw;
        bus.PCS = i.pcs;
        bus.RegW = i.regw;
        bus.MemW = i.memw;
        bus.NoWrite = i.nowr;
        bus.Stall = i.stall;
        bus.CntClr = i.clr;
        ce = mcond(i.cond, mflags);
        cq.push_back({ce, i.pcs & ce & ~i.stall,
                      i.regw & ce & ~i.nowr & ~i.stall,
                      i.memw & ce & ~i.stall});
        #1;
    endtask

    task automatic tick();
        logic ce;
        ce = mcond(cur.cond, mflags);
        if (reset) begin
            if (!cur.stall && ce) begin
                if (cur.flagw[1]) mflags[3:2] = cur.aluf[3:2];
                if (cur.flagw[0]) mflags[1:0] = cur.aluf[1:0];
            end
            if (cur.clr) begin
                mexec = '0; mskip = '0; mundef = 1'b0;
            end else if (!cur.stall) begin
                if (ce) mexec = (mexec == 4'd15) ? mexec : mexec + 4'd1;
                else    mskip = (mskip == 4'd15) ? mskip : mskip + 4'd1;
                if (cur.cond == 4'b1111) mundef = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        sq.push_back({mflags, mexec, mskip, mundef});
    endtask

    task automatic test_reset();
        instr_t p[$];
        logic [3:0] ec;
        logic [12:0] es;
        p.push_back(mk(4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0));
        p.push_back(mk(4'h1, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0));
        p.push_back(mk(4'hE, 4'hF, 2'b11, 0, 0, 1, 0, 0, 1));
        foreach (p[k]) begin
            drive(p[k]);
            ec = cq.pop_front();
            checks++;
            if ({bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite} !== ec) begin
                failures++;
                $display("FAIL reset_comb[%0d] got=%b exp=%b", k,
                         {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite}, ec);
            end
            tick();
            es = sq.pop_front();
            checks++;
            if ({bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen} !== es) begin
                failures++;
                $display("FAIL reset_state[%0d] got=%h exp=%h", k,
                         {bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen}, es);
            end
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_flags();
        instr_t p[$];
        logic [3:0] ec;
        logic [12:0] es;
        p.push_back(mk(4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0));
        p.push_back(mk(4'h1, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0));
        p.push_back(mk(4'hE, 4'b0110, 2'b11, 0, 0, 0, 0, 0, 0));
        p.push_back(mk(4'h0, 4'h0, 2'b00, 1, 1, 1, 0, 0, 0));
        p.push_back(mk(4'h8, 4'h0, 2'b00, 1, 1, 1, 0, 0, 0));
        p.push_back(mk(4'hE, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0));
        p.push_back(mk(4'hA, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0));
        p.push_back(mk(4'hC, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0));
        p.push_back(mk(4'hE, 4'b0000, 2'b01, 0, 0, 0, 0, 0, 0));
        p.push_back(mk(4'hA, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0));
        p.push_back(mk(4'hB, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0));
        p.push_back(mk(4'h0, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0));
        p.push_back(mk(4'h1, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0));
        p.push_back(mk(4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0));
        p.push_back(mk(4'h1, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0));
        p.push_back(mk(4'hE, 4'b0010, 2'b11, 0, 1, 0, 1, 0, 0));
        p.push_back(mk(4'h9, 4'h0, 2'b00, 0, 0, 1, 0, 0, 0));
        p.push_back(mk(4'hD, 4'h0, 2'b00, 0, 0, 1, 0, 0, 0));
        foreach (p[k]) begin
            drive(p[k]);
            ec = cq.pop_front();
            checks++;
            if ({bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite} !== ec) begin
                failures++;
                $display("FAIL flags_comb[%0d] got=%b exp=%b", k,
                         {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite}, ec);
            end
            tick();
            es = sq.pop_front();
            checks++;
            if ({bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen} !== es) begin
                failures++;
                $display("FAIL flags_state[%0d] got=%h exp=%h", k,
                         {bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen}, es);
            end
        end
    endtask

    task automatic test_stall();
        instr_t p[$];
        logic [3:0] ec;
        logic [12:0] es;
        p.push_back(mk(4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 1, 0));
        p.push_back(mk(4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 1, 1));
        p.push_back(mk(4'hF, 4'hF, 2'b11, 1, 1, 1, 0, 1, 0));
        p.push_back(mk(4'hE, 4'b0101, 2'b11, 1, 1, 1, 0, 0, 0));
        foreach (p[k]) begin
            drive(p[k]);
            ec = cq.pop_front();
            checks++;
            if ({bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite} !== ec) begin
                failures++;
                $display("FAIL stall_comb[%0d] got=%b exp=%b", k,
                         {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite}, ec);
            end
            tick();
            es = sq.pop_front();
            checks++;
            if ({bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen} !== es) begin
                failures++;
                $display("FAIL stall_state[%0d] got=%h exp=%h", k,
                         {bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen}, es);
            end
        end
    endtask

    task automatic test_saturate();
        instr_t p[$];
        logic [3:0] ec;
        logic [12:0] es;
        for (int j = 0; j < 20; j++)
            p.push_back(mk(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0));
        p.push_back(mk(4'hF, 4'h0, 2'b11, 1, 1, 1, 0, 0, 0));
        p.push_back(mk(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0));
        p.push_back(mk(4'h6, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0));
        p.push_back(mk(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 1));
        foreach (p[k]) begin
            drive(p[k]);
            ec = cq.pop_front();
            checks++;
            if ({bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite} !== ec) begin
                failures++;
                $display("FAIL sat_comb[%0d] got=%b exp=%b", k,
                         {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite}, ec);
            end
            tick();
            es = sq.pop_front();
            checks++;
            if ({bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen} !== es) begin
                failures++;
                $display("FAIL sat_state[%0d] got=%h exp=%h", k,
                         {bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen}, es);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ec;
        logic [12:0] es;
        drive(mk(4'hE, 4'b1111, 2'b11, 0, 1, 0, 0, 0, 0));
        void'(cq.pop_front());
        tick();
        es = sq.pop_front();
        checks++;
        if (bus.Flags !== es[12:9]) begin
            failures++;
            $display("FAIL rmid_pre got=%b exp=%b", bus.Flags, es[12:9]);
        end
        drive(mk(4'hE, 4'b0101, 2'b11, 0, 1, 0, 0, 0, 0));
        void'(cq.pop_front());
        #1 reset = 1'b0;
        mflags = 4'b0000; mexec = '0; mskip = '0; mundef = 1'b0;
        #1;
        checks++;
        if ({bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen} !== 13'h0) begin
            failures++;
            $display("FAIL rmid_async got=%h exp=0",
                     {bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen});
        end
        drive(mk(4'h1, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0));
        ec = cq.pop_front();
        checks++;
        if ({bus.CondEx, bus.PCSrc} !== ec[3:2]) begin
            failures++;
            $display("FAIL rmid_comb got=%b exp=%b", {bus.CondEx, bus.PCSrc}, ec[3:2]);
        end
        tick();
        es = sq.pop_front();
        checks++;
        if ({bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen} !== es) begin
            failures++;
            $display("FAIL rmid_hold got=%h exp=%h",
                     {bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen}, es);
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ec;
        logic [12:0] es;
        instr_t i;
        int bad;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            i = mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 19) == 0));
            drive(i);
            ec = cq.pop_front();
            checks++;
            if ({bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite} !== ec) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL b2b_comb[%0d] got=%b exp=%b", k,
                             {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite}, ec);
            end
            tick();
            es = sq.pop_front();
            checks++;
            if ({bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen} !== es) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL b2b_state[%0d] got=%h exp=%h", k,
                             {bus.Flags, bus.ExecCount, bus.SkipCount, bus.UndefSeen}, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_stall();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage directly downstream of the ALU in the single-cycle ARM datapath. Holds the architectural NZCV flag register, which is loaded from the ALU's 4-bit flag output. Evaluates the instruction's 4-bit condition field against the stored flags and gates the PC-source, register-write and memory-write enables. Also keeps saturating executed/skipped instruction counters and a sticky undefined-condition indicator for debug.

## Interface
- CNT_W, 32, width of ExecCount and SkipCount
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
- Cond  input  4  instruction condition field, Instr[31:28]
- ALUFlags  input  4  ALU flags of the current instruction: [3]=N, [2]=Z, [1]=C, [0]=V
- FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V
- PCS  input  1  decoder: instruction writes PC
- RegW  input  1  decoder: instruction writes register file
- MemW  input  1  decoder: instruction writes memory
- NoWrite  input  1  decoder: compare-type op (CMP/CMN/TST), suppresses RegWrite
- Stall  input  1  current cycle holds no valid instruction; freezes all state
- CntClr  input  1  synchronous clear of counters and UndefSeen
- CondEx  output  1  condition passed, combinational
- PCSrc  output  1  PCS & CondEx & ~Stall
- RegWrite  output  1  RegW & CondEx & ~NoWrite & ~Stall
- MemWrite  output  1  MemW & CondEx & ~Stall
- Flags  output  4  registered NZCV, same bit order as ALUFlags
- ExecCount  output  CNT_W  instructions with CondEx=1
- SkipCount  output  CNT_W  instructions with CondEx=0
- UndefSeen  output  1  sticky: a Cond=4'b1111 instruction was committed

## Operation
- CondEx is computed from the registered Flags, never from ALUFlags, so flags set by instruction i affect instruction i+1 onward.
- Condition decode (N,Z,C,V = Flags):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111 gives CondEx=0.
- CondEx itself is not gated by Stall. Only the three enables, the flag update and the counters are gated.
- Flag update at the clock edge, only when ~Stall & CondEx:
  - FlagW[1] loads Flags[3:2] from ALUFlags[3:2].
  - FlagW[0] loads Flags[1:0] from ALUFlags[1:0].
  - Both bits set loads all four flags. A failed condition leaves Flags unchanged.
- Counters and UndefSeen, at the clock edge:
  - CntClr=1: both counters go to 0 and UndefSeen goes to 0. CntClr wins over any increment in the same cycle, including while Stall=1.
  - Otherwise, when ~Stall: CondEx=1 increments ExecCount; CondEx=0 increments SkipCount.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - Cond=1111 with ~Stall sets UndefSeen, which stays set until CntClr or reset.
- Flags are not affected by CntClr.

## Timing
- Reset values: Flags=4'b0000, ExecCount=0, SkipCount=0, UndefSeen=0.
- With reset asserted, combinational outputs still follow the inputs using Flags=0. For example Cond=EQ gives CondEx=0; Cond=NE gives CondEx=1.
- Latency:
  - CondEx, PCSrc, RegWrite, MemWrite: 0 cycles, combinational within the instruction's cycle.
  - Flags, counters, UndefSeen: visible 1 cycle after the committing edge.
- Same-cycle case: an instruction with FlagW≠0 evaluates its own condition against the old flags. The new flags apply from the next cycle.
- Reset deasserted mid-program: state restarts from the reset values. No partial flag update survives.
- Stall=1 for N cycles: all registered state holds for exactly N edges, and PCSrc, RegWrite and MemWrite stay 0 throughout.

## Test plan
- Reset then Cond=0000 with PCS=1 → CondEx=0, PCSrc=0. Cond=0001 with RegW=1 → RegWrite=1. SkipCount=1 then ExecCount=1 after the respective edges.
- Cond=1110, FlagW=2'b11, ALUFlags=4'b0110 → next cycle Flags=0110. Then Cond=0000 → CondEx=1, and Cond=1000 (HI) → CondEx=0.
- Flags=1001 with Cond=1010 (GE) → CondEx=1. Cond=1100 (GT) → CondEx=1. With Cond=1110, FlagW=2'b01, ALUFlags=0000 → Flags=1000; then GE → CondEx=0 and LT → CondEx=1.
- Cond fails with FlagW=11 and ALUFlags=1111 → Flags unchanged, RegWrite=0, MemWrite=0, SkipCount increments by 1. Separately, NoWrite=1 with RegW=1 and Cond=AL → RegWrite=0 while the flags still update.
- Stall=1 for 3 cycles with Cond=AL, FlagW=11, RegW=1 → enables 0, Flags and counters frozen. CntClr=1 during the stall → both counters 0 on the next cycle.
- With CNT_W=4, run 20 AL instructions → ExecCount holds at 15. Then Cond=1111 → CondEx=0, UndefSeen=1 persists; CntClr → UndefSeen=0.
